ss_sched: RTL and testbench
===========================

# ss_sched

Shared single-shot scheduler for the G-15 I/O timing path: arbitrates up to N requesters for one tick-driven down-counter and grants each winner a timed shot of its own requested duration. Replaces per-device single-shot instances where device timing windows (typewriter strobe, tape punch, reader settle) are mutually exclusive. Sits between the device controllers and the common `tick` timebase. Round-robin fairness, non-overlapping shots, one-cycle completion strobe.

## Interface
- `N`, 4: number of requesters (2..8)
- `W`, 8: duration/counter width in bits
- `GAP`, 2: guard interval in ticks between shots; used only with `SS_SCHED_GAP_EN`; must fit in W bits
- `clk`  in  1  system clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `tick`  in  1  timebase strobe, one clk wide; counter advances only on `tick`
- `req`  in  N  level request per requester; held until its `done`
- `dur`  in  N*W  per-requester duration in ticks, slice i = `dur[i*W +: W]`
- `abort`  in  1  cancels the shot in progress
- `gnt`  out  N  one-hot grant, high for the whole shot
- `done`  out  N  one-hot, one clk, final cycle of a completed shot
- `sel`  out  max(1,$clog2(N))  index of current/last grantee
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, GAP (GAP exists only with `SS_SCHED_GAP_EN`).
- Registers: `state`, `ctr[W-1:0]`, `last` (last granted index), `sel`.
- IDLE: if `req != 0`, pick first set bit searching `last+1, last+2, ... ` mod N; `ctr <= dur[pick]`, `sel <= pick`, `last <= pick`, go RUN. Else stay.
- `dur` sampled once at grant; later changes ignored for that shot.
- RUN: `gnt = onehot(sel)`. If `ctr == 0`: `done = onehot(sel)` this cycle, go GAP (macro on, `ctr <= GAP`) or IDLE. Else if `tick`: `ctr <= ctr - 1`.
- GAP: no `gnt`; if `ctr == 0` go IDLE, else if `tick` decrement.
- Dropping `req` mid-shot is ignored; shot runs to completion.
- `abort` in RUN: go IDLE (macro off) or GAP (macro on, `ctr <= GAP`) next cycle; no `done`; `last` keeps aborted index so rotation advances. `abort` in IDLE/GAP ignored. `abort` on the `ctr == 0` cycle: completion wins, `done` asserted.
- `tick` and `ctr == 0` in same RUN cycle: completion, no decrement (no underflow).
- `dur = 0`: single-cycle grant with `done` in that same cycle.
- Counter never wraps; saturates at 0.

## Timing
- Reset (any state, including mid-shot): next cycle `state = IDLE`, `ctr = 0`, `gnt = 0`, `done = 0`, `busy = 0`, `sel = 0`, `last = N-1` (requester 0 wins first).
- `gnt`, `busy` decoded from registered state: request seen in IDLE at cycle c -> `gnt` from c+1.
- Shot length with `tick` every clk: `gnt` high dur+1 clks; `done` on last of them.
- Shot length general: `gnt` spans `dur` ticks plus one terminal clk.
- Back-to-back, macro off: `done` at cycle d -> IDLE at d+1 -> next `gnt` at d+2.
- `done` combinational from registered state/ctr; never asserted outside RUN.

## Configuration
- `SS_SCHED_GAP_EN` defined: GAP state compiled in; after every completed or aborted shot, `busy` stays high with no `gnt` for GAP ticks, then IDLE.
- Not defined: GAP state and parameter use removed; RUN returns directly to IDLE; `GAP` parameter ignored.

## Test plan
- N=4, W=8, tick every clk, `req=4'b0100`, `dur[2]=5` at cycle 0 -> `gnt=4'b0100` cycles 1-6, `done=4'b0100` cycle 6 only, `sel=2`, `busy` 1-6.
- `req=4'b1111` held, all `dur=1`, macro off -> grant order 0,1,2,3,0; each `gnt` 2 clks; 2-clk spacing between grant starts after `done`.
- tick every 4th clk, `req[1]`, `dur[1]=3` -> `gnt[1]` held until 3rd tick after grant plus one clk; `ctr` changes only on tick cycles.
- `dur[0]=0`, `req=4'b0001` -> `gnt[0]` and `done[0]` both high exactly one clk (cycle 1).
- `req=4'b0011`, `dur=10`, `abort` at cycle 4 -> `gnt` zero from cycle 5, no `done`, next grant to requester 1; repeat with `abort` on terminal cycle -> `done` asserted.
- `rst` at cycle 3 of a shot -> cycle 4 all outputs 0, next grant to requester 0; with `SS_SCHED_GAP_EN`, GAP=2, tick every clk -> `busy=1`, `gnt=0` for 3 clks after `done`.

Source files
------------

// File: rtl/ss_sched.sv
// ---------------------------------------------------------------------------
// ss_sched -- shared single-shot scheduler
//
// Several device controllers share one tick-driven down-counter. A requester
// is chosen round-robin and given a timed shot of the duration it asked for.
// Shots never overlap.
//
// Optional feature macro: SS_SCHED_GAP_EN
//   When defined, every completed or aborted shot is followed by a guard
//   interval of GAP ticks. busy stays high and gnt stays low during it.
//   When undefined, RUN returns straight to IDLE and GAP is ignored.
//
// Parameters
//   N    number of requesters (2..8)
//   W    duration / counter width in bits
//   GAP  guard interval in ticks (only used with SS_SCHED_GAP_EN)
//
// Ports
//   clk        system clock, single domain
//   rst        synchronous, active-high reset
//   tick       timebase strobe, one clk wide; the counter moves only on tick
//   req[N]     level request per requester, held until its done
//   dur[N*W]   per-requester duration in ticks, slice i = dur[i*W +: W]
//   abort      cancels the shot in progress (ignored outside RUN)
//   gnt[N]     one-hot grant, high for the whole shot
//   done[N]    one-hot, one clk, final cycle of a completed shot
//   sel        index of the current / last grantee
//   busy       high in any state other than IDLE
//   dbg_state  raw FSM state (0 IDLE, 1 RUN, 2 GAP)
//   dbg_ctr    raw shot / guard counter
//
// Handshake: req is a level. Once a requester is picked in IDLE, its dur
// slice is captured and the shot runs to completion or abort, whatever req
// does afterwards. A shot is complete in the cycle where done is high. A
// requester that still holds req after its done can compete again from the
// following IDLE cycle.
// ---------------------------------------------------------------------------
module ss_sched #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int GAP = 2,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dur,
  input  logic           abort,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic [SW-1:0]  sel,
  output logic           busy,
  output logic [1:0]     dbg_state,
  output logic [W-1:0]   dbg_ctr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
`ifdef SS_SCHED_GAP_EN
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [W-1:0] GAP_W = W'(GAP);
`endif

  logic [1:0]    r_state;
  logic [W-1:0]  r_ctr;
  logic [SW-1:0] r_last;
  logic [SW-1:0] r_sel;

  logic [W-1:0]  w_dur [N];
  logic [SW-1:0] w_pick;
  logic          w_found;
  logic [N-1:0]  w_sel_oh;
  logic          w_run;
  logic          w_ctr_zero;

`ifndef SS_SCHED_GAP_EN
  // GAP has no effect in this build; referenced only to keep it visible.
  logic w_unused_gap;
  assign w_unused_gap = ^GAP;
`endif

  // Unpack the flat duration bus into one slice per requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_dur[i] = dur[i*W +: W];
    end
  end

  // Round-robin pick: first set request searching last+1, last+2, ... mod N.
  // The last requester in the search order is the one granted last time, so
  // it only wins again when nobody else is asking.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!w_found && req[(int'(r_last) + k) % N]) begin
        w_found = 1'b1;
        w_pick  = SW'((int'(r_last) + k) % N);
      end
    end
  end

  assign w_run      = (r_state == ST_RUN);
  assign w_ctr_zero = (r_ctr == '0);
  assign w_sel_oh   = N'(1) << r_sel;

  // Outputs are decoded from registered state only. done uses ctr == 0, so a
  // zero-length shot produces gnt and done in the same single cycle.
  assign gnt       = w_run ? w_sel_oh : '0;
  assign done      = (w_run && w_ctr_zero) ? w_sel_oh : '0;
  assign busy      = (r_state != ST_IDLE);
  assign sel       = r_sel;
  assign dbg_state = r_state;
  assign dbg_ctr   = r_ctr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ctr   <= '0;
      r_last  <= SW'(N - 1);   // requester 0 is first in the search order
      r_sel   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            // Duration captured once here; later changes to dur are ignored.
            r_ctr   <= w_dur[w_pick];
            r_sel   <= w_pick;
            r_last  <= w_pick;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Completion is checked before abort and before tick: an abort on
          // the terminal cycle still completes, and a tick at zero never
          // underflows the counter.
          if (w_ctr_zero) begin
`ifdef SS_SCHED_GAP_EN
            r_ctr   <= GAP_W;
            r_state <= ST_GAP;
`else
            r_state <= ST_IDLE;
`endif
          end else if (abort) begin
            // r_last already holds the aborted index, so rotation moves on.
`ifdef SS_SCHED_GAP_EN
            r_ctr   <= GAP_W;
            r_state <= ST_GAP;
`else
            r_ctr   <= '0;
            r_state <= ST_IDLE;
`endif
          end else if (tick) begin
            r_ctr <= r_ctr - 1'b1;
          end
        end

`ifdef SS_SCHED_GAP_EN
        ST_GAP: begin
          if (w_ctr_zero) begin
            r_state <= ST_IDLE;
          end else if (tick) begin
            r_ctr <= r_ctr - 1'b1;
          end
        end
`endif

        default: begin
          r_state <= ST_IDLE;
          r_ctr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ss_sched.sv
// ---------------------------------------------------------------------------
// tb_ss_sched -- directed self-checking bench for ss_sched (N=4, W=8, GAP=2).
// Expected grants are queued when a request is driven and popped by a monitor
// when a new grant appears; per-cycle values are checked inline.
// ---------------------------------------------------------------------------
module tb_ss_sched;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 2;
  localparam int SW  = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           tick;
  logic [N-1:0]   req;
  logic [N*W-1:0] dur;
  logic           abort;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [SW-1:0]  sel;
  logic           busy;
  logic [1:0]     dbg_state;
  logic [W-1:0]   dbg_ctr;

  ss_sched #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .req       (req),
    .dur       (dur),
    .abort     (abort),
    .gnt       (gnt),
    .done      (done),
    .sel       (sel),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_ctr   (dbg_ctr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: expected one-hot grant of each shot, in order
  logic [N-1:0] exp_q[$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] order [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dur(input int i, input logic [W-1:0] v);
    dur[i*W +: W] = v;
  endtask

  // monitor: new grant pops the scoreboard; done must match the live grant
  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(gnt), 32'd0);
      else                   chk("sb_grant_order", 32'(gnt), 32'(exp_q.pop_front()));
    end
    if (done != '0) chk("done_in_run", 32'(done), 32'(gnt));
    prev_gnt = gnt;
  end

  initial begin
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    rst = 1'b1; tick = 1'b1; abort = 1'b0; req = '0; dur = '0;

    // reset state
    step(); step();
    chk("rst_gnt",  32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel",  32'(sel), 0);
    chk("rst_ctr",  32'(dbg_ctr), 0);
    rst = 1'b0;
    step();

    // single shot, dur=5, tick every clk: gnt cycles 1-6, done at 6
    set_dur(2, 8'd5); req = 4'b0100; exp_q.push_back(4'b0100);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk("t1_gnt",  32'(gnt), 32'b0100);
      chk("t1_done", 32'(done), (c == 6) ? 32'b0100 : 32'b0);
      chk("t1_sel",  32'(sel), 2);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_ctr",  32'(dbg_ctr), 32'(6 - c));
    end
    req = '0;
    step();
    chk("t1_idle_gnt",  32'(gnt), 0);
    chk("t1_idle_busy", 32'(busy), 0);

    // round robin, all requesting, dur=1: 0,1,2,3,0 with 3-clk period
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < N; i++) set_dur(i, 8'd1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(order[i]);
    for (int c = 1; c <= 14; c++) begin
      step();
      chk("t2_gnt",  32'(gnt),  (c % 3 != 0) ? 32'(order[c/3]) : 32'b0);
      chk("t2_done", 32'(done), (c % 3 == 2) ? 32'(order[c/3]) : 32'b0);
      if (c == 14) req = '0;
    end
    step();
    chk("t2_idle_busy", 32'(busy), 0);

    // tick every 4th clk, dur=3: ticks at cycles 3,7,11 -> done at 12
    tick = 1'b0; set_dur(1, 8'd3); req = 4'b0010; exp_q.push_back(4'b0010);
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("t3_gnt",  32'(gnt), 32'b0010);
      chk("t3_done", 32'(done), (c == 12) ? 32'b0010 : 32'b0);
      chk("t3_ctr",  32'(dbg_ctr), 32'(3 - c / 4));
      tick = (c % 4 == 3);
      if (c == 12) req = '0;
    end
    tick = 1'b1;
    step();
    chk("t3_idle_gnt", 32'(gnt), 0);

    // zero duration: gnt and done together for exactly one clk
    set_dur(0, 8'd0); req = 4'b0001; exp_q.push_back(4'b0001);
    step();
    chk("t4_gnt",  32'(gnt), 32'b0001);
    chk("t4_done", 32'(done), 32'b0001);
    chk("t4_busy", 32'(busy), 1);
    req = '0;
    step();
    chk("t4_after_gnt",  32'(gnt), 0);
    chk("t4_after_done", 32'(done), 0);
    chk("t4_after_busy", 32'(busy), 0);

    // abort mid-shot at cycle 4, then abort on terminal cycle of next shot
    rst = 1'b1; step(); rst = 1'b0;
    set_dur(0, 8'd10); set_dur(1, 8'd10); req = 4'b0011;
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("t5_gnt", 32'(gnt),
          (c <= 4) ? 32'b0001 : ((c >= 6 && c <= 16) ? 32'b0010 : 32'b0));
      chk("t5_done", 32'(done), (c == 16) ? 32'b0010 : 32'b0);
      if (c == 5) chk("t5_abort_busy", 32'(busy), 0);
      abort = (c == 4 || c == 16);
      if (c == 16) req = '0;
    end
    abort = 1'b0;
    chk("t5_idle_busy", 32'(busy), 0);

    // reset at cycle 3 of a shot; requester 0 wins next despite req[2]
    set_dur(2, 8'd5); req = 4'b0100; exp_q.push_back(4'b0100);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("t6_gnt", 32'(gnt), 32'b0100);
    end
    rst = 1'b1;
    step();
    chk("t6_rst_gnt",  32'(gnt), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_sel",  32'(sel), 0);
    chk("t6_rst_ctr",  32'(dbg_ctr), 0);
    rst = 1'b0; req = 4'b0101; set_dur(0, 8'd2); exp_q.push_back(4'b0001);
    for (int c = 5; c <= 7; c++) begin
      step();
      chk("t6_gnt0",  32'(gnt), 32'b0001);
      chk("t6_done0", 32'(done), (c == 7) ? 32'b0001 : 32'b0);
      if (c == 7) req = '0;
    end
    step();
    chk("t6_idle_busy", 32'(busy), 0);

    // shot followed by guard interval (or straight to IDLE)
    set_dur(0, 8'd1); req = 4'b0001; exp_q.push_back(4'b0001);
    for (int c = 1; c <= 2; c++) begin
      step();
      chk("t7_gnt",  32'(gnt), 32'b0001);
      chk("t7_done", 32'(done), (c == 2) ? 32'b0001 : 32'b0);
    end
    req = '0;
`ifdef SS_SCHED_GAP_EN
    for (int c = 3; c <= 5; c++) begin
      step();
      chk("t7_gap_busy", 32'(busy), 1);
      chk("t7_gap_gnt",  32'(gnt), 0);
      chk("t7_gap_ctr",  32'(dbg_ctr), 32'(5 - c));
    end
    step();
    chk("t7_gap_end_busy", 32'(busy), 0);
`else
    step();
    chk("t7_nogap_busy", 32'(busy), 0);
`endif

    // abort while idle is ignored; the grant still happens
    abort = 1'b1; set_dur(1, 8'd0); req = 4'b0010; exp_q.push_back(4'b0010);
    step();
    chk("t8_gnt",  32'(gnt), 32'b0010);
    chk("t8_done", 32'(done), 32'b0010);
    abort = 1'b0; req = '0;
    step();
    chk("t8_gnt_off", 32'(gnt), 0);
    step(); step(); step(); step();

    // final report
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
